// File: rtl/inst_cache_ctrl.sv
// Direct-mapped, read-only instruction cache with a block-read miss controller.
// Hits are served combinationally; a miss fetches and installs a whole line.
module inst_cache_ctrl #(
  parameter int unsigned NUM_LINES  = 8,
  parameter int unsigned BLOCK_SIZE = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [31:0]             PC,
  input  logic                    FetchReq,
  input  logic                    FetchAbort,
  output logic [31:0]             Instr,
  output logic                    Hit,
  output logic                    Stall,
  output logic [31:0]             MemAddress,
  output logic                    MemReadMiss,
  input  logic [32*BLOCK_SIZE-1:0] MemReadData,
  input  logic                    MemReadReady,
  output logic                    MemAbort,
  output logic [31:0]             MissCount
);

  localparam int unsigned Off  = $clog2(BLOCK_SIZE);
  localparam int unsigned OffW = (Off > 0) ? Off : 1;
  localparam int unsigned Idx  = $clog2(NUM_LINES);
  localparam int unsigned TagW = 30 - Off - Idx;
  localparam logic [31:0] BlockMask = 32'(BLOCK_SIZE * 4 - 1);

  typedef enum logic [1:0] {
    StIdle,
    StMissWait,
    StAborting
  } state_e;

  state_e                  state_q;
  logic [NUM_LINES-1:0]    valid_q;
  logic [TagW-1:0]         tag_q   [NUM_LINES];
  logic [32*BLOCK_SIZE-1:0] data_q [NUM_LINES];
  logic [Idx-1:0]          fill_idx_q;
  logic [TagW-1:0]         fill_tag_q;
  logic [31:0]             mem_address_q;
  logic [31:0]             miss_count_q;
  logic                    mem_abort_q;

  logic [OffW-1:0]         pc_off;
  logic [Idx-1:0]          pc_idx;
  logic [TagW-1:0]         pc_tag;
  logic [31:0]             line_words [BLOCK_SIZE];
  logic                    hit;
  logic                    fill_we;

  // Address split: byte bits ignored, then word offset, index, tag.
  if (Off > 0) begin : g_off
    assign pc_off = PC[Off+1:2];
  end else begin : g_no_off
    assign pc_off = '0;
  end
  assign pc_idx = PC[Off+2 +: Idx];
  assign pc_tag = PC[31 -: TagW];

  always_comb begin
    for (int k = 0; k < BLOCK_SIZE; k++) begin
      line_words[k] = data_q[pc_idx][32*k +: 32];
    end
  end

  assign hit = FetchReq && (state_q == StIdle) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  assign Hit         = hit;
  assign Instr       = hit ? line_words[pc_off] : 32'h0;
  assign Stall       = FetchReq && !hit;
  assign MemReadMiss = (state_q == StMissWait);
  assign MemAddress  = mem_address_q;
  assign MemAbort    = mem_abort_q;
  assign MissCount   = miss_count_q;

  // A ready pulse wins over a same-cycle abort: the fill completes normally.
  assign fill_we = (state_q == StMissWait) && MemReadReady;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= StIdle;
      valid_q       <= '0;
      fill_idx_q    <= '0;
      fill_tag_q    <= '0;
      mem_address_q <= '0;
      miss_count_q  <= '0;
      mem_abort_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (FetchReq && !hit) begin
            mem_address_q <= PC & ~BlockMask;
            fill_idx_q    <= pc_idx;
            fill_tag_q    <= pc_tag;
            miss_count_q  <= miss_count_q + 32'd1;
            state_q       <= StMissWait;
          end
        end
        StMissWait: begin
          if (MemReadReady) begin
            valid_q[fill_idx_q] <= 1'b1;
            state_q             <= StIdle;
          end else if (FetchAbort) begin
            mem_abort_q <= 1'b1;
            state_q     <= StAborting;
          end
        end
        StAborting: begin
          mem_abort_q <= 1'b0;
          state_q     <= StIdle;
        end
        default: begin
          mem_abort_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  // Line payload needs no reset; the valid bits gate every use.
  always_ff @(posedge Clk) begin
    if (fill_we) begin
      data_q[fill_idx_q] <= MemReadData;
      tag_q[fill_idx_q]  <= fill_tag_q;
    end
  end

endmodule

// File: tb/tb_inst_cache_ctrl.sv
// Directed bench for inst_cache_ctrl: the bench plays the block memory and
// queues expected instruction words that are checked when a hit appears.
module tb_inst_cache_ctrl;

  localparam int unsigned NL = 8;
  localparam int unsigned BS = 4;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [31:0]     PC;
  logic            FetchReq;
  logic            FetchAbort;
  logic [31:0]     Instr;
  logic            Hit;
  logic            Stall;
  logic [31:0]     MemAddress;
  logic            MemReadMiss;
  logic [32*BS-1:0] MemReadData;
  logic            MemReadReady;
  logic            MemAbort;
  logic [31:0]     MissCount;

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_miss = 0;
  logic [31:0] exp_q[$];

  inst_cache_ctrl #(
    .NUM_LINES  (NL),
    .BLOCK_SIZE (BS)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .PC           (PC),
    .FetchReq     (FetchReq),
    .FetchAbort   (FetchAbort),
    .Instr        (Instr),
    .Hit          (Hit),
    .Stall        (Stall),
    .MemAddress   (MemAddress),
    .MemReadMiss  (MemReadMiss),
    .MemReadData  (MemReadData),
    .MemReadReady (MemReadReady),
    .MemAbort     (MemAbort),
    .MissCount    (MissCount)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [32*BS-1:0] blk(input logic [31:0] base);
    logic [32*BS-1:0] r;
    for (int k = 0; k < BS; k++) r[32*k +: 32] = base + 32'(k);
    return r;
  endfunction

  // Expected word for a fetch at pc from a line filled with base+k.
  task automatic expect_word(input logic [31:0] base, input logic [31:0] pc);
    exp_q.push_back(base + ((pc >> 2) & 32'(BS - 1)));
  endtask

  task automatic check_hit(input string tag);
    logic [31:0] e;
    chk({tag, ".hit"}, 32'(Hit), 32'd1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s.instr observed=%h expected=<empty scoreboard>", tag, Instr);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".instr"}, Instr, e);
    end
  endtask

  // Memory side: ready pulse with block data after 'delay' wait cycles.
  task automatic serve(input logic [31:0] base, input int delay, input logic abort_same);
    repeat (delay - 1) tick();
    MemReadData  = blk(base);
    MemReadReady = 1'b1;
    FetchAbort   = abort_same;
    tick();
    MemReadReady = 1'b0;
    FetchAbort   = 1'b0;
    settle();
  endtask

  initial begin
    Rst = 1'b0; PC = '0; FetchReq = 1'b0; FetchAbort = 1'b0;
    MemReadReady = 1'b0; MemReadData = '0;
    #2;
    chk("rst.hit", 32'(Hit), 32'd0);
    chk("rst.instr", Instr, 32'h0);
    chk("rst.readmiss", 32'(MemReadMiss), 32'd0);
    chk("rst.abort", 32'(MemAbort), 32'd0);
    chk("rst.addr", MemAddress, 32'h0);
    chk("rst.misscount", MissCount, 32'd0);
    chk("rst.stall0", 32'(Stall), 32'd0);
    FetchReq = 1'b1;
    settle();
    chk("rst.stall1", 32'(Stall), 32'd1);
    FetchReq = 1'b0;
    tick(); tick();
    Rst = 1'b1;

    // Cold miss at 0x40.
    PC = 32'h40; FetchReq = 1'b1;
    settle();
    chk("cold.nohit", 32'(Hit), 32'd0);
    chk("cold.stall", 32'(Stall), 32'd1);
    tick(); exp_miss++;
    chk("cold.readmiss", 32'(MemReadMiss), 32'd1);
    chk("cold.addr", MemAddress, 32'h40);
    chk("cold.misscount", MissCount, 32'(exp_miss));
    serve(32'h1000, 20, 1'b0);
    expect_word(32'h1000, PC);
    check_hit("cold");
    chk("cold.readmiss_off", 32'(MemReadMiss), 32'd0);
    chk("cold.misscount2", MissCount, 32'(exp_miss));

    // Hits in the filled line.
    PC = 32'h44; expect_word(32'h1000, PC);
    settle();
    check_hit("hit44");
    chk("hit44.stall", 32'(Stall), 32'd0);
    chk("hit44.readmiss", 32'(MemReadMiss), 32'd0);
    tick();
    PC = 32'h4C; expect_word(32'h1000, PC);
    settle();
    check_hit("hit4c");
    tick();
    chk("hit.misscount", MissCount, 32'(exp_miss));

    // Abort on wait cycle 5.
    PC = 32'h100;
    settle();
    chk("abort.nohit", 32'(Hit), 32'd0);
    tick(); exp_miss++;
    chk("abort.readmiss", 32'(MemReadMiss), 32'd1);
    chk("abort.addr", MemAddress, 32'h100);
    chk("abort.misscount", MissCount, 32'(exp_miss));
    repeat (4) tick();
    FetchAbort = 1'b1;
    settle();
    chk("abort.pre", 32'(MemAbort), 32'd0);
    tick();
    FetchAbort = 1'b0;
    settle();
    chk("abort.pulse", 32'(MemAbort), 32'd1);
    chk("abort.readmiss_off", 32'(MemReadMiss), 32'd0);
    chk("abort.stall", 32'(Stall), 32'd1);
    tick();
    chk("abort.pulse_end", 32'(MemAbort), 32'd0);
    chk("abort.line_invalid", 32'(Hit), 32'd0);
    chk("abort.idle", 32'(MemReadMiss), 32'd0);
    tick(); exp_miss++;
    chk("abort.remiss", 32'(MemReadMiss), 32'd1);
    chk("abort.misscount2", MissCount, 32'(exp_miss));

    // Abort coincident with ready: fill wins, no abort pulse.
    serve(32'h2000, 6, 1'b1);
    chk("coinc.abort", 32'(MemAbort), 32'd0);
    expect_word(32'h2000, PC);
    check_hit("coinc");
    tick();
    chk("coinc.abort2", 32'(MemAbort), 32'd0);
    chk("coinc.readmiss", 32'(MemReadMiss), 32'd0);

    // Conflict eviction on line 0, with PC moving during one wait.
    PC = 32'h00;
    settle();
    chk("conf0.nohit", 32'(Hit), 32'd0);
    tick(); exp_miss++;
    serve(32'h3000, 3, 1'b0);
    expect_word(32'h3000, PC);
    check_hit("conf0");
    PC = 32'h80;
    settle();
    chk("conf80.nohit", 32'(Hit), 32'd0);
    tick(); exp_miss++;
    chk("conf80.addr", MemAddress, 32'h80);
    PC = 32'h44;
    settle();
    chk("conf80.nohit_wait", 32'(Hit), 32'd0);
    chk("conf80.addr_held", MemAddress, 32'h80);
    serve(32'h4000, 3, 1'b0);
    expect_word(32'h1000, PC);
    check_hit("conf80.newpc");
    PC = 32'h8C; expect_word(32'h4000, PC);
    settle();
    check_hit("conf80");
    PC = 32'h00;
    settle();
    chk("conf0b.nohit", 32'(Hit), 32'd0);
    tick(); exp_miss++;
    chk("conf.misscount", MissCount, 32'(exp_miss));
    serve(32'h5000, 3, 1'b0);
    PC = 32'h04; expect_word(32'h5000, PC);
    settle();
    check_hit("conf0b");

    // Reset during a miss.
    PC = 32'h200;
    settle();
    chk("rmid.nohit", 32'(Hit), 32'd0);
    tick(); exp_miss++;
    chk("rmid.readmiss", 32'(MemReadMiss), 32'd1);
    #3;
    Rst = 1'b0;
    #1;
    exp_miss = 0;
    chk("rmid.readmiss_off", 32'(MemReadMiss), 32'd0);
    chk("rmid.misscount", MissCount, 32'(exp_miss));
    chk("rmid.addr", MemAddress, 32'h0);
    tick();
    #2;
    Rst = 1'b1;
    PC = 32'h40;
    settle();
    chk("rmid.invalid", 32'(Hit), 32'd0);
    chk("rmid.stall", 32'(Stall), 32'd1);
    tick(); exp_miss++;
    chk("rmid.misscount2", MissCount, 32'(exp_miss));
    chk("rmid.addr2", MemAddress, 32'h40);
    serve(32'h6000, 2, 1'b0);
    expect_word(32'h6000, PC);
    check_hit("rmid.refill");

    FetchReq = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
